// File: rtl/audio_pwm_gen_pkg.sv
// Shared audio package: modulator state encoding and the default sample
// width. The output selector and sibling audio sources import it as well.
package audio_pwm_gen_pkg;

  localparam int AUDIO_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } audio_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Sample buffer between the PCM producer and the PWM modulator.
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   push, din     write request and data (ignored while full)
//   pop, dout     read request (ignored while empty); dout shows the head entry
//   level         occupancy, 0..FIFO_DEPTH
//   full, empty   occupancy flags
module sample_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read once level says they exist.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/audio_pwm_gen.sv
// Audio PWM generator: buffers PCM samples and turns each one into a single
// PWM period of 2^DATA_W counter steps, each step CLK_DIV system clocks long.
// Ports:
//   clk, rst       system clock, asynchronous active-low reset
//   enable         run control; low returns to IDLE (buffer contents kept)
//   sample_in/_valid/_ready  sample push handshake
//   pwm_out        registered PWM bit
//   underflow      one-cycle pulse when a period ends with the buffer empty
//   fifo_level     buffer occupancy
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | disabled; prescaler, pcnt, duty held at 0; buffer still fills
// ST_PRIME | enabled, waiting for a prescaler tick with a sample available
// ST_RUN   | modulating; a new duty is taken at every period boundary
module audio_pwm_gen
  import audio_pwm_gen_pkg::*;
#(
  parameter int DATA_W     = AUDIO_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                PSC_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(CLK_DIV - 1);
  localparam logic [DATA_W-1:0] PCNT_LAST = '1;

  audio_state_e      state_q, state_d;
  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [DATA_W-1:0] pcnt_q, pcnt_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic              underflow_q, underflow_d;

  logic              tick, boundary;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  assign sample_ready = !fifo_full;
  assign fifo_push    = sample_valid && sample_ready;

  assign tick     = (state_q != ST_IDLE) && (psc_q == PSC_LAST);
  assign boundary = (state_q == ST_RUN) && tick && (pcnt_q == PCNT_LAST);

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    psc_d       = psc_q;
    pcnt_d      = pcnt_q;
    duty_d      = duty_q;
    fifo_pop    = 1'b0;
    underflow_d = 1'b0;
    // Compare uses the current pcnt/duty, so the output lags them by a clock.
    pwm_d       = (state_q == ST_RUN) && (pcnt_q < duty_q);

    if (state_q != ST_IDLE) psc_d = tick ? '0 : psc_q + PSC_W'(1);

    if (!enable) begin
      state_d = ST_IDLE;
      psc_d   = '0;
      pcnt_d  = '0;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_PRIME;
        ST_PRIME: begin
          if (tick && !fifo_empty) begin
            fifo_pop = 1'b1;
            duty_d   = fifo_dout;
            pcnt_d   = '0;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            pcnt_d = pcnt_q + DATA_W'(1);
            // Empty at the boundary: keep the old duty and flag it. A sample
            // pushed in this same cycle waits for the next boundary.
            if (boundary) begin
              if (!fifo_empty) begin
                fifo_pop = 1'b1;
                duty_d   = fifo_dout;
              end else begin
                underflow_d = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      psc_q       <= '0;
      pcnt_q      <= '0;
      duty_q      <= '0;
      pwm_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psc_q       <= psc_d;
      pcnt_q      <= pcnt_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
      underflow_q <= underflow_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_audio_pwm_gen.sv
// Bench for audio_pwm_gen: directed scenarios followed by random pushes and
// enable drops. A timeline model predicts every PWM pulse (rise/fall cycle)
// and every underflow pulse; a monitor compares them as the DUT emits them.
module tb_audio_pwm_gen;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CLK_DIV    = 2;
  localparam int NSTEP      = 1 << DATA_W;
  localparam int PERIOD     = NSTEP * CLK_DIV;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              pwm_out;
  logic              underflow;
  logic [LVL_W-1:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  audio_pwm_gen #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .underflow    (underflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: mode 0 idle, 1 prime, 2 run. Time in PRIME and RUN is
  // counted in clocks; step and period position come from plain division.
  int mq[$];
  int m_mode   = 0;
  int prime_t  = 0;
  int run_t    = 0;
  int cur_duty = 0;
  bit exp_pwm  = 1'b0;
  bit nxt_pwm  = 1'b0;
  bit m_push   = 1'b0;
  int exp_rise = 0;
  int m_cyc    = 0;
  int pulse_rise_q[$];
  int pulse_fall_q[$];
  int uf_q[$];

  // Interval k is the time between posedge k and posedge k+1.
  initial forever begin
    @(posedge clk);
    m_cyc++;
    if (!rst) begin
      mq.delete();
      m_mode   = 0;
      cur_duty = 0;
      nxt_pwm  = 1'b0;
    end else begin
      m_push  = sample_valid && (mq.size() < FIFO_DEPTH);
      nxt_pwm = (m_mode == 2) && (((run_t / CLK_DIV) % NSTEP) < cur_duty);
      if (!enable) begin
        m_mode   = 0;
        cur_duty = 0;
      end else if (m_mode == 0) begin
        m_mode  = 1;
        prime_t = 0;
      end else if (m_mode == 1) begin
        if ((prime_t % CLK_DIV) == CLK_DIV - 1 && mq.size() > 0) begin
          cur_duty = mq.pop_front();
          m_mode   = 2;
          run_t    = 0;
        end else begin
          prime_t++;
        end
      end else begin
        if ((run_t % PERIOD) == PERIOD - 1) begin
          if (mq.size() > 0) cur_duty = mq.pop_front();
          else uf_q.push_back(m_cyc);
        end
        run_t++;
      end
      if (m_push) mq.push_back(int'(sample_in));
    end
    if (nxt_pwm && !exp_pwm) exp_rise = m_cyc;
    if (!nxt_pwm && exp_pwm) begin
      pulse_rise_q.push_back(exp_rise);
      pulse_fall_q.push_back(m_cyc);
    end
    exp_pwm = nxt_pwm;
  end

  // Asynchronous reset cuts the current interval short.
  initial forever begin
    @(negedge rst);
    if (exp_pwm && exp_rise != m_cyc) begin
      pulse_rise_q.push_back(exp_rise);
      pulse_fall_q.push_back(m_cyc);
    end
    if (uf_q.size() > 0 && uf_q[$] == m_cyc) void'(uf_q.pop_back());
    exp_pwm  = 1'b0;
    mq.delete();
    m_mode   = 0;
    cur_duty = 0;
  end

  int mon_cyc  = 0;
  bit mon_prev = 1'b0;
  int mon_rise = 0;

  initial forever begin
    @(negedge clk);
    mon_cyc++;
    if (pwm_out && !mon_prev) mon_rise = mon_cyc;
    if (!pwm_out && mon_prev) begin
      if (pulse_rise_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pwm_pulse: got pulse %0d..%0d, expected none", mon_rise, mon_cyc);
      end else begin
        check("pwm_rise", mon_rise, pulse_rise_q.pop_front());
        check("pwm_fall", mon_cyc, pulse_fall_q.pop_front());
      end
    end
    mon_prev = pwm_out;
    if (underflow) begin
      if (uf_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow: got pulse at %0d, expected none", mon_cyc);
      end else begin
        check("underflow_cyc", mon_cyc, uf_q.pop_front());
      end
    end
  end

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic drive(input bit v, input int d);
    sample_valid = v;
    sample_in    = DATA_W'(d);
    if (v) begin
      check("sample_ready", int'(sample_ready), (mq.size() < FIFO_DEPTH) ? 1 : 0);
      check("fifo_level", int'(fifo_level), mq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  int r;

  initial begin
    rst          = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_underflow", int'(underflow), 0);
    check("rst_ready", int'(sample_ready), 1);
    check("rst_level", int'(fifo_level), 0);
    rst = 1'b1;
    idle(2);

    // Disabled: four pushes fill the buffer, the fifth is refused.
    drive(1'b1, 'h10);
    drive(1'b1, 'h80);
    drive(1'b1, 'hF0);
    drive(1'b1, 'h00);
    drive(1'b1, 'h33);
    drive(1'b0, 0);
    check("full_level", int'(fifo_level), 4);
    check("full_ready", int'(sample_ready), 0);
    idle(50);

    // Periods 0x10, 0x80, 0xF0, 0x00, then underflow holding 0, then 0xFF.
    enable = 1'b1;
    idle(4 * PERIOD + PERIOD / 2);
    drive(1'b1, 'hFF);
    idle(2 * PERIOD);

    // Long PRIME with an empty buffer, then a single 0x20 sample.
    enable = 1'b0;
    idle(5);
    check("drain_level", int'(fifo_level), 0);
    enable = 1'b1;
    idle(1000);
    drive(1'b1, 'h20);
    idle(3 * PERIOD);

    // Random pushes, bursts and enable drops.
    for (int i = 0; i < 20000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        drive(1'b1, int'($urandom_range(0, NSTEP - 1)));
      end else if (r == 998) begin
        for (int j = 0; j < 5; j++) drive(1'b1, int'($urandom_range(0, NSTEP - 1)));
      end else if (r == 999) begin
        enable = 1'b0;
        idle(int'($urandom_range(1, 30)));
        enable = 1'b1;
      end else begin
        drive(1'b0, 0);
      end
    end

    // Reset mid-period with three samples buffered.
    enable = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    enable = 1'b1;
    drive(1'b1, 'h80);
    idle(10);
    drive(1'b1, 1);
    drive(1'b1, 2);
    drive(1'b1, 3);
    idle(200);
    check("pre_rst_level", int'(fifo_level), 3);
    check("pre_rst_pwm", int'(pwm_out), 1);
    rst = 1'b0;
    #1;
    check("rst_mid_pwm", int'(pwm_out), 0);
    check("rst_mid_level", int'(fifo_level), 0);
    check("rst_mid_underflow", int'(underflow), 0);
    @(posedge clk);
    #1;
    idle(3);
    rst = 1'b1;
    idle(600);
    check("prime_level", int'(fifo_level), 0);
    enable = 1'b0;
    idle(10);

    check("pulses_left", pulse_rise_q.size(), 0);
    check("underflows_left", uf_q.size(), 0);
    check("pwm_idle_end", int'(pwm_out), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
